// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad-to-ALU sequencer for the BCD calculator datapath
//
// Builds two 4-digit BCD operands and an add/subtract operator from keypad
// events, selects the display source and flags when a result is shown.
//
// Ports:
//   clk        system clock (LF oscillator)
//   reset      asynchronous, active-high
//   key_valid  keypad level, high while a key is held
//   key_tipo   0 = digit key, 1 = command key
//   key_code   digit 0-9 or command (A add, B sub, C equals, F clear)
//   reg1/reg2  BCD operands, most significant digit in [15:12]
//   regop      ALU operator, 0 = add, 1 = subtract
//   oe         one-hot display select: 001 reg1, 010 reg2, 100 result
//   res_valid  one-cycle pulse when a result becomes displayed
//   state      current FSM state for debug/LED
module calc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic        key_tipo,
  input  logic [3:0]  key_code,
  output logic [15:0] reg1,
  output logic [15:0] reg2,
  output logic        regop,
  output logic [2:0]  oe,
  output logic        res_valid,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    OP1    = 3'b001,
    OPW    = 3'b010,
    OP2    = 3'b011,
    RESULT = 3'b100
  } state_t;

  localparam logic [3:0] CMD_ADD = 4'hA;
  localparam logic [3:0] CMD_SUB = 4'hB;
  localparam logic [3:0] CMD_EQ  = 4'hC;
  localparam logic [3:0] CMD_CLR = 4'hF;

  state_t      cur;
  logic        kv_q;
  logic [2:0]  cnt1;
  logic [2:0]  cnt2;
  logic        key_event;
  logic        is_digit;
  logic        is_op;
  logic        is_eq;
  logic        is_clr;
  logic [15:0] reg1_shift;
  logic [15:0] reg2_shift;

  // One event per press: only the low-to-high transition of the held level counts.
  assign key_event  = key_valid & ~kv_q;
  assign is_digit   = key_event & ~key_tipo & (key_code <= 4'd9);
  assign is_op      = key_event & key_tipo & ((key_code == CMD_ADD) | (key_code == CMD_SUB));
  assign is_eq      = key_event & key_tipo & (key_code == CMD_EQ);
  assign is_clr     = key_event & key_tipo & (key_code == CMD_CLR);
  assign reg1_shift = {reg1[11:0], key_code};
  assign reg2_shift = {reg2[11:0], key_code};
  assign state      = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= IDLE;
      kv_q      <= 1'b0;
      reg1      <= 16'h0000;
      reg2      <= 16'h0000;
      cnt1      <= 3'd0;
      cnt2      <= 3'd0;
      regop     <= 1'b0;
      oe        <= 3'b001;
      res_valid <= 1'b0;
    end else begin
      kv_q      <= key_valid;
      res_valid <= 1'b0;
      if (is_clr) begin
        cur   <= IDLE;
        reg1  <= 16'h0000;
        reg2  <= 16'h0000;
        cnt1  <= 3'd0;
        cnt2  <= 3'd0;
        regop <= 1'b0;
        oe    <= 3'b001;
      end else begin
        case (cur)
          IDLE, OP1: begin
            // Leading zeros shift in but do not consume one of the four digit slots.
            if (is_digit && cnt1 != 3'd4) begin
              reg1 <= reg1_shift;
              if (reg1_shift != 16'h0000) cnt1 <= cnt1 + 3'd1;
            end
            if (is_digit) cur <= OP1;
            if (cur == OP1 && is_op) begin
              regop <= key_code[0];
              reg2  <= 16'h0000;
              cnt2  <= 3'd0;
              oe    <= 3'b010;
              cur   <= OPW;
            end
          end
          OPW, OP2: begin
            if (is_digit && cnt2 != 3'd4) begin
              reg2 <= reg2_shift;
              if (reg2_shift != 16'h0000) cnt2 <= cnt2 + 3'd1;
            end
            if (cur == OPW) begin
              if (is_digit) cur <= OP2;
              if (is_op) regop <= key_code[0];
            end else if (is_eq) begin
              cur       <= RESULT;
              oe        <= 3'b100;
              res_valid <= 1'b1;
            end
          end
          RESULT: begin
            // Operands hold so the ALU output stays stable until a new digit starts over.
            if (is_digit) begin
              reg1  <= {12'h000, key_code};
              cnt1  <= (key_code != 4'd0) ? 3'd1 : 3'd0;
              reg2  <= 16'h0000;
              cnt2  <= 3'd0;
              regop <= 1'b0;
              oe    <= 3'b001;
              cur   <= OP1;
            end
          end
          default: cur <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic        key_tipo;
  logic [3:0]  key_code;
  logic [15:0] reg1;
  logic [15:0] reg2;
  logic        regop;
  logic [2:0]  oe;
  logic        res_valid;
  logic [2:0]  state;
  logic [39:0] obs;
  int          checks;
  int          errors;

  calc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_tipo  (key_tipo),
    .key_code  (key_code),
    .reg1      (reg1),
    .reg2      (reg2),
    .regop     (regop),
    .oe        (oe),
    .res_valid (res_valid),
    .state     (state)
  );

  assign obs = {reg1, reg2, regop, oe, res_valid, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic t, input logic [3:0] c);
    key_tipo  = t;
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [39:0] exp;
    exp = {16'h0000, 16'h0000, 1'b0, 3'b001, 1'b0, 3'b000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_hold;
    key_tipo  = 1'b0;
    key_code  = 4'd3;
    key_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({reg1, state} !== {16'h0003, 3'b001}) begin
      errors++;
      $display("FAIL hold_first got %h/%b exp 0003/001", reg1, state);
    end
    repeat (9) @(negedge clk);
    checks++;
    if ({reg1, state} !== {16'h0003, 3'b001}) begin
      errors++;
      $display("FAIL hold_after got %h/%b exp 0003/001", reg1, state);
    end
    key_valid = 1'b0;
    @(negedge clk);
    press(1'b1, 4'hF);
  endtask

  task automatic test_calc;
    logic [39:0] exp;
    press(1'b0, 4'd1);
    press(1'b0, 4'd2);
    press(1'b1, 4'hA);
    exp = {16'h0012, 16'h0000, 1'b0, 3'b010, 1'b0, 3'b010};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL calc_opw got %h exp %h", obs, exp);
    end
    press(1'b0, 4'd7);
    key_tipo  = 1'b1;
    key_code  = 4'hC;
    key_valid = 1'b1;
    @(negedge clk);
    exp = {16'h0012, 16'h0007, 1'b0, 3'b100, 1'b1, 3'b100};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL calc_result got %h exp %h", obs, exp);
    end
    key_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL calc_pulse_end got %b exp 0", res_valid);
    end
    press(1'b1, 4'hF);
  endtask

  task automatic test_digits;
    for (int i = 1; i <= 5; i++) press(1'b0, 4'(i));
    checks++;
    if (reg1 !== 16'h1234) begin
      errors++;
      $display("FAIL digits_full got %h exp 1234", reg1);
    end
    press(1'b1, 4'hF);
    press(1'b0, 4'd0);
    press(1'b0, 4'd0);
    press(1'b0, 4'd9);
    checks++;
    if ({reg1, state} !== {16'h0009, 3'b001}) begin
      errors++;
      $display("FAIL digits_lead got %h/%b exp 0009/001", reg1, state);
    end
    // Only one slot used by 0,0,9: three more digits fit, a fourth does not.
    press(1'b0, 4'd1);
    press(1'b0, 4'd2);
    press(1'b0, 4'd3);
    press(1'b0, 4'd4);
    checks++;
    if (reg1 !== 16'h9123) begin
      errors++;
      $display("FAIL digits_count got %h exp 9123", reg1);
    end
    press(1'b1, 4'hF);
  endtask

  task automatic test_ignored;
    logic [39:0] exp;
    press(1'b1, 4'hC);
    press(1'b1, 4'hA);
    press(1'b0, 4'hD);
    press(1'b1, 4'hD);
    press(1'b1, 4'hE);
    exp = {16'h0000, 16'h0000, 1'b0, 3'b001, 1'b0, 3'b000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL ignored_idle got %h exp %h", obs, exp);
    end
    press(1'b0, 4'd8);
    checks++;
    if ({reg1, state} !== {16'h0008, 3'b001}) begin
      errors++;
      $display("FAIL ignored_then_digit got %h/%b exp 0008/001", reg1, state);
    end
    press(1'b1, 4'hF);
  endtask

  task automatic test_clear_op2;
    logic [39:0] exp;
    press(1'b0, 4'd1);
    press(1'b1, 4'hA);
    press(1'b0, 4'd4);
    press(1'b0, 4'd2);
    checks++;
    if ({reg2, state} !== {16'h0042, 3'b011}) begin
      errors++;
      $display("FAIL clear_setup got %h/%b exp 0042/011", reg2, state);
    end
    press(1'b1, 4'hF);
    exp = {16'h0000, 16'h0000, 1'b0, 3'b001, 1'b0, 3'b000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clear_op2 got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_async_reset;
    logic [39:0] exp;
    press(1'b0, 4'd5);
    press(1'b0, 4'd6);
    #2 reset = 1'b1;
    #1;
    exp = {16'h0000, 16'h0000, 1'b0, 3'b001, 1'b0, 3'b000};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", obs, exp);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_result_digit;
    logic [39:0] exp;
    press(1'b0, 4'd1);
    press(1'b0, 4'd2);
    press(1'b1, 4'hB);
    press(1'b0, 4'd7);
    press(1'b1, 4'hC);
    press(1'b1, 4'hA);
    exp = {16'h0012, 16'h0007, 1'b1, 3'b100, 1'b0, 3'b100};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL result_hold got %h exp %h", obs, exp);
    end
    press(1'b0, 4'd8);
    exp = {16'h0008, 16'h0000, 1'b0, 3'b001, 1'b0, 3'b001};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL result_digit got %h exp %h", obs, exp);
    end
    press(1'b1, 4'hF);
  endtask

  task automatic test_op_overwrite;
    press(1'b0, 4'd6);
    press(1'b1, 4'hA);
    press(1'b1, 4'hB);
    checks++;
    if ({regop, oe, state} !== {1'b1, 3'b010, 3'b010}) begin
      errors++;
      $display("FAIL opw_overwrite got %b/%b/%b exp 1/010/010", regop, oe, state);
    end
    press(1'b0, 4'd3);
    press(1'b1, 4'hA);
    checks++;
    if ({regop, reg2, state} !== {1'b1, 16'h0003, 3'b011}) begin
      errors++;
      $display("FAIL op2_no_chain got %b/%h/%b exp 1/0003/011", regop, reg2, state);
    end
    press(1'b1, 4'hF);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_tipo  = 1'b0;
    key_code  = 4'd0;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_hold;
    test_calc;
    test_digits;
    test_ignored;
    test_clear_op2;
    test_async_reset;
    test_result_digit;
    test_op_overwrite;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keypad-to-ALU controller for the calculator datapath. It turns key events from the keypad scanner into two 4-digit BCD operands and one operator. It drives the ALU operand and operator registers, selects which value the display multiplexer shows, and flags when a result is ready. It sits between the keypad block and the ALU/display blocks, all on the single low-frequency oscillator clock.

## Interface
- No parameters. Operand width is fixed at 16 bits: 4 BCD digits, with the most significant digit in bits [15:12].
- clk  in  1  system clock, internal LF oscillator
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values
- key_valid  in  1  level from keypad; high while a key is held
- key_tipo  in  1  0 = digit key, 1 = command key
- key_code  in  4  digit value (0–9) or command code
- reg1  out  16  operand 1, BCD
- reg2  out  16  operand 2, BCD
- regop  out  1  ALU operator; 0 = add, 1 = subtract
- oe  out  3  one-hot display select; 001 = reg1, 010 = reg2, 100 = ALU result
- res_valid  out  1  one-cycle pulse when a result becomes displayed
- state  out  3  current FSM state encoding, for debug/LED

## Operation
- Key acceptance:
  - A key event is a rising edge of key_valid (registered previous value low, current value high).
  - key_tipo and key_code are sampled in that same cycle.
  - Holding key_valid high produces exactly one event.
- Command codes: 1010 = add, 1011 = subtract, 1100 = equals, 1111 = clear. Codes 1101 and 1110 are ignored.
- A digit event with key_code > 9 is ignored.
- Digit entry into the active operand:
  - operand <= {operand[11:0], digit}.
  - The per-operand digit counter (0–4) increments only if the operand is nonzero after the shift, so leading zeros are not counted.
  - When the counter is 4, further digits are ignored (no wrap, no shift).
- States: IDLE=000, OP1=001, OPW=010, OP2=011, RESULT=100.
- IDLE:
  - Digit: enter into reg1, go to OP1.
  - Operator or equals: ignored.
  - oe=001.
- OP1:
  - Digit: enter into reg1.
  - Add/sub: latch regop, clear reg2 and its counter, go to OPW, oe=010.
  - Equals: ignored.
- OPW:
  - Digit: enter into reg2, go to OP2.
  - Add/sub: overwrite regop.
  - Equals: ignored.
  - oe=010.
- OP2:
  - Digit: enter into reg2.
  - Equals: go to RESULT, oe=100, pulse res_valid.
  - Add/sub: ignored (no chaining).
- RESULT:
  - Digit: reg1 <= {12'h000, digit}, reg2 <= 0, both counters reset (reg1 counter = 1 if digit ≠ 0), regop <= 0, go to OP1, oe=001.
  - Operators and equals: ignored.
  - reg1, reg2 and regop hold, so the ALU output stays stable.
- Clear (1111) in any state: reg1=reg2=0, counters=0, regop=0, oe=001, go to IDLE.
- Reset values: reg1=0, reg2=0, regop=0, oe=001, res_valid=0, state=IDLE, counters=0, key_valid history register=0.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N.
- res_valid is high for exactly the one cycle following the edge on which equals was accepted in OP2.
- Reset acts immediately, without waiting for a clock edge.
- On reset deassertion, a key_valid already high is treated as a new rising edge on the first clock, because the history register is 0.
- Reset or clear mid-entry discards partial operands. No state survives.
- The next key needs key_valid low for at least one sampled cycle.
- Throughput: at most one accepted event every 2 cycles.

## Test plan
- Key_valid held high for 10 cycles with key_tipo=0, key_code=3 from IDLE → reg1=16'h0003 after one cycle and unchanged after that; state=001.
- Digits 1, 2, then 1010, then 7, then 1100 → reg1=16'h0012, reg2=16'h0007, regop=0, oe=100, res_valid high exactly one cycle, state=100.
- Digits 1, 2, 3, 4, 5 → reg1=16'h1234; the 5th digit is ignored. Leading 0, 0, 9 → reg1=16'h0009 with counter=1.
- In IDLE press 1100, then 1010, then digit code 4'b1101 with tipo=0 → no change (reg1=0, oe=001, state=000). Then digit 8 → reg1=16'h0008.
- In OP2 with reg2=16'h0042, press 1111 → reg1=reg2=0, oe=001, state=000. Separately, assert reset mid-cycle during OP1 → outputs at reset values before the next clk edge.
- From RESULT (12 − 7, regop=1), press digit 8 → reg1=16'h0008, reg2=0, regop=0, oe=001, state=001. Pressing 1011 in OPW after 1010 leaves regop=1.
